// File: rtl/axi4_wr_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write slave port among N masters.
// One write transaction in flight; W locked to the AW winner until WLAST.
module axi4_wr_rr_arbiter #(
    parameter int N_MASTER = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTER-1:0]            m_awvalid,
    output logic [N_MASTER-1:0]            m_awready,
    input  logic [N_MASTER*ID_W-1:0]       m_awid,
    input  logic [N_MASTER*ADDR_W-1:0]     m_awaddr,
    input  logic [N_MASTER*8-1:0]          m_awlen,
    input  logic [N_MASTER*3-1:0]          m_awsize,
    input  logic [N_MASTER*2-1:0]          m_awburst,
    input  logic [N_MASTER-1:0]            m_wvalid,
    output logic [N_MASTER-1:0]            m_wready,
    input  logic [N_MASTER*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTER*DATA_W/8-1:0]   m_wstrb,
    input  logic [N_MASTER-1:0]            m_wlast,
    output logic [N_MASTER-1:0]            m_bvalid,
    input  logic [N_MASTER-1:0]            m_bready,
    output logic [ID_W-1:0]                m_bid,
    output logic [1:0]                     m_bresp,
    output logic                           s_awvalid,
    input  logic                           s_awready,
    output logic [ID_W-1:0]                s_awid,
    output logic [ADDR_W-1:0]              s_awaddr,
    output logic [7:0]                     s_awlen,
    output logic [2:0]                     s_awsize,
    output logic [1:0]                     s_awburst,
    output logic                           s_wvalid,
    input  logic                           s_wready,
    output logic [DATA_W-1:0]              s_wdata,
    output logic [DATA_W/8-1:0]            s_wstrb,
    output logic                           s_wlast,
    input  logic                           s_bvalid,
    output logic                           s_bready,
    input  logic [ID_W-1:0]                s_bid,
    input  logic [1:0]                     s_bresp,
    output logic [$clog2(N_MASTER)-1:0]    grant_idx,
    output logic                           prot_err
);

    localparam int IDX_W  = $clog2(N_MASTER);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_rr;
    logic [7:0]       r_len;
    logic [7:0]       r_cnt;
    logic             r_prot_err;

    logic [IDX_W-1:0] w_pick;
    logic             w_found;
    logic             w_in_addr;
    logic             w_in_data;
    logic             w_in_resp;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;

    // Phase strobes are masked by rst so an aborted transfer drives nothing.
    assign w_in_addr = (r_state == ADDR) && !rst;
    assign w_in_data = (r_state == DATA) && !rst;
    assign w_in_resp = (r_state == RESP) && !rst;

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        for (int k = 0; k < N_MASTER; k++) begin
            if (!w_found && m_awvalid[(int'(r_rr) + k) % N_MASTER]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'((int'(r_rr) + k) % N_MASTER);
            end
        end
    end

    assign s_awvalid = w_in_addr;
    assign s_awid    = w_in_addr ? m_awid[r_grant*ID_W +: ID_W] : '0;
    assign s_awaddr  = w_in_addr ? m_awaddr[r_grant*ADDR_W +: ADDR_W] : '0;
    assign s_awlen   = w_in_addr ? m_awlen[r_grant*8 +: 8] : '0;
    assign s_awsize  = w_in_addr ? m_awsize[r_grant*3 +: 3] : '0;
    assign s_awburst = w_in_addr ? m_awburst[r_grant*2 +: 2] : '0;

    assign s_wvalid = w_in_data && m_wvalid[r_grant];
    assign s_wdata  = w_in_data ? m_wdata[r_grant*DATA_W +: DATA_W] : '0;
    assign s_wstrb  = w_in_data ? m_wstrb[r_grant*STRB_W +: STRB_W] : '0;
    assign s_wlast  = w_in_data && m_wlast[r_grant];

    assign s_bready = w_in_resp && m_bready[r_grant];
    assign m_bid    = w_in_resp ? s_bid : '0;
    assign m_bresp  = w_in_resp ? s_bresp : '0;

    always_comb begin
        m_awready          = '0;
        m_wready           = '0;
        m_bvalid           = '0;
        m_awready[r_grant] = w_in_addr && s_awready;
        m_wready[r_grant]  = w_in_data && s_wready;
        m_bvalid[r_grant]  = w_in_resp && s_bvalid;
    end

    assign w_aw_hs = w_in_addr && s_awready;
    assign w_w_hs  = s_wvalid && s_wready;
    assign w_b_hs  = w_in_resp && s_bvalid && m_bready[r_grant];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr       <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_prot_err <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_len   <= m_awlen[w_pick*8 +: 8];
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_aw_hs) begin
                        r_cnt   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_w_hs) begin
                        r_cnt <= r_cnt + 8'd1;
                        // Flag early or late WLAST; the burst still ends on WLAST.
                        if (s_wlast) begin
                            if (r_cnt != r_len) r_prot_err <= 1'b1;
                            r_state <= RESP;
                        end else if (r_cnt == r_len) begin
                            r_prot_err <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (w_b_hs) begin
                        r_rr    <= (int'(r_grant) == N_MASTER - 1) ? '0 : r_grant + 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_idx = r_grant;
    assign prot_err  = r_prot_err;

endmodule

// File: doc/axi4_wr_rr_arbiter.md
Name: axi4_wr_rr_arbiter

Overview:
Shares one AXI4 write-slave port (AW/W/B) between N_MASTER write masters. Round-robin grant on AW, W channel locked to the granted master until WLAST, and B response routed back to that master. One write transaction is in flight at a time. Sits in front of shared write-only targets (memory controller write port, CSR bridge). AXLEN/AXSIZE/AXBURST/RESP encodings are those of the team's AMBA4 package.

Parameters:
N_MASTER, 4, number of requesting masters (2..8)
ADDR_W, 32, AWADDR width
DATA_W, 64, WDATA width; WSTRB width is DATA_W/8
ID_W, 4, AWID/BID width (passed through unchanged)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_awvalid  in  N_MASTER  per-master AW valid
m_awready  out  N_MASTER  per-master AW ready
m_awid  in  N_MASTER*ID_W  packed, master i at [i*ID_W +: ID_W]
m_awaddr  in  N_MASTER*ADDR_W  packed
m_awlen  in  N_MASTER*8  packed LEN_T
m_awsize  in  N_MASTER*3  packed SIZE_T
m_awburst  in  N_MASTER*2  packed BURST_T
m_wvalid  in  N_MASTER  per-master W valid
m_wready  out  N_MASTER  per-master W ready
m_wdata  in  N_MASTER*DATA_W  packed
m_wstrb  in  N_MASTER*DATA_W/8  packed
m_wlast  in  N_MASTER  per-master WLAST
m_bvalid  out  N_MASTER  per-master B valid
m_bready  in  N_MASTER  per-master B ready
m_bid  out  ID_W  BID (shared bus; meaningful only with m_bvalid)
m_bresp  out  2  BRESP (shared bus)
s_awvalid/s_awready/s_awid/s_awaddr/s_awlen/s_awsize/s_awburst  out/in/out...  1/1/ID_W/ADDR_W/8/3/2  slave AW channel
s_wvalid/s_wready/s_wdata/s_wstrb/s_wlast  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  slave W channel
s_bvalid/s_bready/s_bid/s_bresp  in/out/in/in  1/1/ID_W/2  slave B channel
grant_idx  out  $clog2(N_MASTER)  index of current/last owner
prot_err  out  1  sticky: WLAST beat count mismatch

Behaviour:
- Clock clk; reset rst synchronous, active-high. On reset: state=IDLE, rr pointer=0, grant_idx=0, prot_err=0, beat counter=0; all valid/ready outputs 0; data buses don't-care (driven 0).
- FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE: if any m_awvalid, pick first requester at or after rr pointer (cyclic scan). Register grant_idx, latch its AWLEN; go ADDR next cycle. No requester: stay.
- ADDR: s_awvalid=1, s_aw* muxed from granted master combinationally; m_awready[grant]=s_awready, others 0. On s_awvalid&&s_awready: beat counter=0, go DATA. Other masters' AW stay stalled.
- DATA: s_wvalid=m_wvalid[grant], m_wready[grant]=s_wready, s_w* muxed from grant; other m_wready=0. Each W handshake increments counter (8-bit). On handshake with wlast=1: if counter != latched AWLEN, set prot_err; go RESP. Beat without wlast at counter==AWLEN also sets prot_err (burst continues until wlast).
- W data presented before AW acceptance is not forwarded (m_wready=0 outside DATA).
- RESP: s_bready=m_bready[grant]; m_bvalid[grant]=s_bvalid, others 0; m_bid/m_bresp=s_bid/s_bresp. On B handshake: rr pointer=(grant+1) mod N_MASTER, go IDLE.
- Throughput: min 1 idle cycle between transactions (IDLE arbitration cycle); AW latency IDLE->s_awvalid = 1 cycle.
- Fairness: a continuously requesting master waits at most N_MASTER-1 transactions.
- AWBURST/AWSIZE passed through unmodified; RSVD burst not checked.
- prot_err cleared only by rst. Reset mid-transaction aborts to IDLE with no further handshakes driven.

Test Plan:
- Single master 0, AWLEN=3 INCR, 4 beats, BRESP=OKAY -> s_aw* equals master 0 fields, 4 W beats forwarded, m_bvalid[0]=1 with BRESP=2'b00, prot_err=0.
- Masters 0..3 all request continuously, AWLEN=0 each -> grant order 0,1,2,3,0; grant_idx matches each AW handshake.
- Master 2 granted, master 1 asserts m_wvalid during master 2 burst -> m_wready[1]=0 throughout; no master 1 data on s_wdata.
- AWLEN=3 with wlast on 2nd beat -> prot_err=1 after that beat, FSM goes RESP, stays 1 after next transactions.
- s_wready toggled 1/0 each cycle, s_bvalid delayed 5 cycles, BRESP=SLVERR -> all beats delivered in order, m_bresp=2'b10 to owner only.
- rst asserted in DATA state -> next cycle all valids/readies 0, grant_idx=0, next request from master 3 granted from IDLE.
